// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants and helpers for the updown_counter family.
//   MODE_WRAP / MODE_SATURATE : values for the SATURATE parameter.
//   default_max(width)        : largest value representable in 'width' bits,
//                               used as the default top of the count range.
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

    // The 32-bit case is handled separately because 1 << 32 overflows a 32-bit
    // shift result.
    function automatic logic [31:0] default_max(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage : counter_pkg

// File: rtl/counter_step.sv
// -----------------------------------------------------------------------------
// counter_step
// Purely combinational single-step calculator for the up/down counter.
// Given the current count and direction it produces the value after one
// enabled step, plus the overflow/underflow indication for that step.
//   count      in   WIDTH  current registered count (always 0..MAX_VALUE)
//   up         in   1      1 = step up, 0 = step down
//   next_count out  WIDTH  count after one step
//   overflow   out  1      step was an up step taken at MAX_VALUE
//   underflow  out  1      step was a down step taken at 0
// -----------------------------------------------------------------------------
module counter_step
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] MAX_VALUE = default_max(WIDTH),
    parameter int          SATURATE  = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic [WIDTH-1:0] next_count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VALUE[WIDTH-1:0];
    localparam bit               SAT   = (SATURATE == MODE_SATURATE);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // through the block leaves a value unassigned and no latch is inferred.
        next_count = count;
        overflow   = 1'b0;
        underflow  = 1'b0;

        if (up) begin
            // Compare against the limit before adding, so the add never needs
            // a carry-out even when MAX_VALUE is the all-ones value.
            if (count == MAX_W) begin
                overflow   = 1'b1;
                next_count = SAT ? MAX_W : '0;
            end else begin
                next_count = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
                underflow  = 1'b1;
                next_count = SAT ? '0 : MAX_W;
            end else begin
                next_count = count - WIDTH'(1);
            end
        end
    end

endmodule : counter_step

// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
// Parametrised synchronous up/down counter with parallel load, wrap or
// saturate behaviour at the range limits, and overflow/underflow/terminal
// flags. Count range is 0..MAX_VALUE.
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   enable     in   1      take one step per clock while high
//   up         in   1      direction of the step (1 = up)
//   load       in   1      synchronous parallel load (beats enable)
//   load_value in   WIDTH  load data, clamped to MAX_VALUE
//   count      out  WIDTH  registered count
//   overflow   out  1      registered pulse: up step taken at MAX_VALUE
//   underflow  out  1      registered pulse: down step taken at 0
//   terminal   out  1      combinational: next step in 'up' direction hits a limit
// -----------------------------------------------------------------------------
module updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] MAX_VALUE = default_max(WIDTH),
    parameter int          SATURATE  = MODE_WRAP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [WIDTH-1:0] w_step_count;
    logic             w_step_overflow;
    logic             w_step_underflow;
    logic [WIDTH-1:0] w_load_clamped;

    counter_step #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX_VALUE),
        .SATURATE  (SATURATE)
    ) u_step (
        .count      (r_count),
        .up         (up),
        .next_count (w_step_count),
        .overflow   (w_step_overflow),
        .underflow  (w_step_underflow)
    );

    // Clamping every load keeps the count inside 0..MAX_VALUE at all times.
    assign w_load_clamped = (load_value > MAX_W) ? MAX_W : load_value;

    // Priority: reset > load > enable > hold. Flags only survive one cycle.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (load) begin
            r_count     <= w_load_clamped;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (enable) begin
            r_count     <= w_step_count;
            r_overflow  <= w_step_overflow;
            r_underflow <= w_step_underflow;
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end
    end

    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // Depends only on the registered count and the live direction input.
    assign terminal  = up ? (r_count == MAX_W) : (r_count == '0);

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_counter
// Three counters driven from shared controls:
//   dut 0 : WIDTH=8, defaults (0..255, wrap)
//   dut 1 : WIDTH=4, MAX_VALUE=9, wrap
//   dut 2 : WIDTH=4, saturate (0..15)
// A reference model tracks every counter with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_updown_counter;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, enable, up, load;
    logic [7:0] load_value;

    logic [7:0] count_a;
    logic [3:0] count_b, count_c;
    logic       ovf_a, ovf_b, ovf_c;
    logic       unf_a, unf_b, unf_c;
    logic       term_a, term_b, term_c;

    updown_counter u_a (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(count_a), .overflow(ovf_a),
        .underflow(unf_a), .terminal(term_a)
    );

    updown_counter #(.WIDTH(4), .MAX_VALUE(9)) u_b (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value[3:0]), .count(count_b), .overflow(ovf_b),
        .underflow(unf_b), .terminal(term_b)
    );

    updown_counter #(.WIDTH(4), .SATURATE(1)) u_c (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value[3:0]), .count(count_c), .overflow(ovf_c),
        .underflow(unf_c), .terminal(term_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int m_cnt[3];
    int m_max[3] = '{255, 9, 15};
    bit m_sat[3] = '{1'b0, 1'b0, 1'b1};
    bit m_ovf[3];
    bit m_unf[3];

    // Observed outputs packed as {count(32), overflow, underflow, terminal}.
    logic [34:0] obs[3];
    always_comb begin
        obs[0] = {32'(count_a), ovf_a, unf_a, term_a};
        obs[1] = {32'(count_b), ovf_b, unf_b, term_b};
        obs[2] = {32'(count_c), ovf_c, unf_c, term_c};
    end

    function automatic logic [34:0] expect_vec(input int k);
        bit t;
        t = up ? (m_cnt[k] == m_max[k]) : (m_cnt[k] == 0);
        return {32'(m_cnt[k]), m_ovf[k], m_unf[k], t};
    endfunction

    // Drive one clock of stimulus, advance the model, return at the negedge.
    task automatic cycle(input bit r, input bit l, input bit e, input bit u,
                         input logic [7:0] lv);
        int v;
        reset = r; load = l; enable = e; up = u; load_value = lv;
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            v = (k == 0) ? int'(lv) : int'(lv[3:0]);
            if (r) begin
                m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            end else if (l) begin
                m_cnt[k] = (v > m_max[k]) ? m_max[k] : v;
                m_ovf[k] = 0; m_unf[k] = 0;
            end else if (e) begin
                m_ovf[k] = u  && (m_cnt[k] == m_max[k]);
                m_unf[k] = !u && (m_cnt[k] == 0);
                if (u)
                    m_cnt[k] = m_sat[k] ? ((m_cnt[k] + 1 > m_max[k]) ? m_max[k] : m_cnt[k] + 1)
                                        : (m_cnt[k] + 1) % (m_max[k] + 1);
                else
                    m_cnt[k] = m_sat[k] ? ((m_cnt[k] == 0) ? 0 : m_cnt[k] - 1)
                                        : (m_cnt[k] + m_max[k]) % (m_max[k] + 1);
            end else begin
                m_ovf[k] = 0; m_unf[k] = 0;
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== expect_vec(k))
                $display("FAIL reset_model dut%0d: got %h want %h", k, obs[k], expect_vec(k));
            else n_pass++;
        end
        n_checks++;
        if ({count_a, ovf_a, unf_a, term_a} !== {8'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_state: got cnt=%0d o=%b u=%b t=%b want 0 0 0 1",
                     count_a, ovf_a, unf_a, term_a);
        else n_pass++;
        up = 1'b1;
        #1;
        n_checks++;
        if (term_a !== 1'b0) $display("FAIL reset_term_up: got %b want 0", term_a);
        else n_pass++;
    endtask

    task automatic test_wrap_full();
        int hits = 0, hit_at = -1;
        cycle(1, 0, 0, 1, 8'h00);
        for (int i = 1; i <= 260; i++) begin
            cycle(0, 0, 1, 1, 8'h00);
            if (ovf_a === 1'b1) begin hits++; hit_at = i; end
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs[k] !== expect_vec(k))
                    $display("FAIL wrap_model dut%0d step %0d: got %h want %h",
                             k, i, obs[k], expect_vec(k));
                else n_pass++;
            end
        end
        n_checks++;
        if (hits !== 1 || hit_at !== 256)
            $display("FAIL wrap_overflow: got %0d pulses last at %0d want 1 at 256", hits, hit_at);
        else n_pass++;
        n_checks++;
        if (count_a !== 8'd4) $display("FAIL wrap_final: got %0d want 4", count_a);
        else n_pass++;
    endtask

    task automatic test_modulus();
        cycle(0, 1, 0, 1, 8'd12);
        n_checks++;
        if (count_b !== 4'd9 || term_b !== 1'b1)
            $display("FAIL mod_load: got cnt=%0d t=%b want 9 1", count_b, term_b);
        else n_pass++;
        cycle(0, 0, 1, 1, 8'd0);
        n_checks++;
        if (count_b !== 4'd0 || ovf_b !== 1'b1 || unf_b !== 1'b0)
            $display("FAIL mod_up: got cnt=%0d o=%b u=%b want 0 1 0", count_b, ovf_b, unf_b);
        else n_pass++;
        cycle(0, 0, 1, 0, 8'd0);
        n_checks++;
        if (count_b !== 4'd9 || unf_b !== 1'b1 || ovf_b !== 1'b0)
            $display("FAIL mod_down: got cnt=%0d o=%b u=%b want 9 0 1", count_b, ovf_b, unf_b);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== expect_vec(k))
                $display("FAIL mod_model dut%0d: got %h want %h", k, obs[k], expect_vec(k));
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        int exp_cnt[5] = '{1, 0, 0, 0, 0};
        bit exp_unf[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        cycle(0, 1, 0, 0, 8'd2);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0, 8'd0);
            n_checks++;
            if (32'(count_c) !== 32'(exp_cnt[i]) || unf_c !== exp_unf[i] || ovf_c !== 1'b0)
                $display("FAIL sat_down step %0d: got cnt=%0d u=%b o=%b want %0d %b 0",
                         i, count_c, unf_c, ovf_c, exp_cnt[i], exp_unf[i]);
            else n_pass++;
        end
    endtask

    task automatic test_load_priority();
        cycle(0, 1, 1, 1, 8'd7);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== expect_vec(k))
                $display("FAIL loadpri_model dut%0d: got %h want %h", k, obs[k], expect_vec(k));
            else n_pass++;
        end
        n_checks++;
        if (count_a !== 8'd7 || ovf_a !== 1'b0 || unf_a !== 1'b0)
            $display("FAIL load_priority: got cnt=%0d o=%b u=%b want 7 0 0", count_a, ovf_a, unf_a);
        else n_pass++;
    endtask

    task automatic test_reset_priority();
        cycle(0, 1, 0, 0, 8'd5);
        cycle(1, 1, 1, 0, 8'd5);
        n_checks++;
        if ({count_a, ovf_a, unf_a, term_a} !== {8'd0, 1'b0, 1'b0, 1'b1} ||
            {count_b, ovf_b, unf_b, term_b} !== {4'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_priority: got a=%h b=%h want cnt 0 flags 0 term 1",
                     {count_a, ovf_a, unf_a, term_a}, {count_b, ovf_b, unf_b, term_b});
        else n_pass++;
    endtask

    task automatic test_direction_toggle();
        logic [7:0] exp_seq[4] = '{8'd4, 8'd3, 8'd4, 8'd3};
        cycle(0, 1, 0, 1, 8'd3);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, (i % 2 == 0), 8'd0);
            n_checks++;
            if (count_a !== exp_seq[i] || 32'(count_b) !== 32'(exp_seq[i]) ||
                {ovf_a, unf_a, ovf_b, unf_b, ovf_c, unf_c} !== 6'b0)
                $display("FAIL toggle step %0d: got a=%0d b=%0d flags=%b want %0d flags 0",
                         i, count_a, count_b, {ovf_a, unf_a, ovf_b, unf_b, ovf_c, unf_c}, exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                  8'($urandom_range(0, 255)));
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs[k] !== expect_vec(k))
                    $display("FAIL random dut%0d cycle %0d: got %h want %h",
                             k, i, obs[k], expect_vec(k));
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up = 1'b0; load = 1'b0; load_value = 8'h00;
        @(negedge clock);
        test_reset();
        test_wrap_full();
        test_modulus();
        test_saturate();
        test_load_priority();
        test_reset_priority();
        test_direction_toggle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_updown_counter

// File: doc/updown_counter.md
# updown_counter

Parametrised synchronous up/down counter, the next generation of the team's 8-bit free-running counter. Adds configurable width and modulus, count enable, direction control, parallel load, selectable wrap or saturate mode, and overflow/underflow/terminal-count flags. Intended as the general-purpose event/timer counter for testbench timebases and small datapath controllers.

## Interface
- WIDTH, 8: counter width in bits; legal range 2..32.
- MAX_VALUE, 2**WIDTH-1: top of count range, so the count range is 0..MAX_VALUE; must satisfy 1 <= MAX_VALUE <= 2**WIDTH-1.
- SATURATE, 0: 0 selects wrap mode; 1 selects saturate mode.

- clock  input  1  rising-edge clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; one step per clock while high.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value for load.
- count  output  WIDTH  registered counter value.
- overflow  output  1  registered one-cycle pulse on an up step at MAX_VALUE.
- underflow  output  1  registered one-cycle pulse on a down step at 0.
- terminal  output  1  combinational: (up && count==MAX_VALUE) || (!up && count==0).

## Operation
- Priority at each rising clock edge: reset > load > enable > hold.
- reset=1: count=0, overflow=0, underflow=0.
- load=1: count=min(load_value, MAX_VALUE); flags cleared; enable ignored.
- enable=1, up=1:
  - count<MAX_VALUE: count+1.
  - count==MAX_VALUE: wrap mode goes to 0; saturate mode holds MAX_VALUE. overflow=1 in both modes.
- enable=1, up=0:
  - count>0: count-1.
  - count==0: wrap mode goes to MAX_VALUE; saturate mode holds 0. underflow=1 in both modes.
- enable=0: count holds; flags clear.
- Overflow and underflow are never both set.
- Arithmetic is WIDTH bits. The increment is compared against MAX_VALUE before the add, so no carry-out is needed when MAX_VALUE=2**WIDTH-1.
- Direction may change on any cycle. The new direction applies to the step taken at that edge.
- Out-of-range count cannot occur, because every load is clamped.

## Timing
- All outputs except terminal are registered. They update one clock after the inputs are sampled.
- terminal has zero latency from count and up. Only count, up and parameters feed it, so there is no combinational path from enable, load or reset.
- Flags are exactly one cycle wide per offending step. A held enable at a saturated limit re-asserts the flag on every cycle.
- Reset values: count=0, overflow=0, underflow=0. After reset, terminal = !up.
- Reset is honoured on any cycle, including mid-count and together with load or enable.
- No asynchronous behaviour. The simulation state before the first reset is undefined and is not checked.

## Structure
- Package counter_pkg:
  - mode constants MODE_WRAP=0 and MODE_SATURATE=1;
  - a function returning the default MAX_VALUE for a given width.
- One sub-module, counter_step. It is purely combinational and computes next value, overflow and underflow from count, up, MAX_VALUE and SATURATE.
- updown_counter contains only:
  - the priority mux (reset/load/enable);
  - the output registers;
  - the terminal decode.

## Test plan
- WIDTH=8 defaults; reset, then enable=1, up=1 for 260 clocks.
  - count reaches 255, then wraps to 0.
  - overflow pulses exactly once, on the 256th step; count=4 at the end.
- WIDTH=4, MAX_VALUE=9; load load_value=12.
  - count=9, terminal=1.
  - One up step gives count=0 and overflow=1.
  - Down from 0 gives count=9 and underflow=1.
- WIDTH=4, SATURATE=1; count down from 2 for 5 enabled cycles.
  - count sequence is 1,0,0,0,0.
  - underflow is high on the last 3 cycles.
- Assert load=1 and enable=1 together with load_value=7: count=7, no step taken.
- Assert reset=1 together with load=1 and enable=1 while count=5.
  - Next cycle count=0 and flags=0.
  - With up=0, terminal=1.
- Toggle up every cycle with enable=1 starting at count=3: count alternates 4,3,4,3 with no flags.
